// File: rtl/imem_loader.sv
// imem_loader: write side of the CPU instruction memory.
// Accepts a framed little-endian byte stream (SYNC, CNT_LO, CNT_HI, 4*CNT data
// bytes, CSUM), assembles 32-bit words, writes them to the memory write port,
// validates an XOR checksum and holds the CPU in reset until a good image loads.
module imem_loader #(
  parameter int          DEPTH  = 32,
  parameter int          ADDR_W = 5,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              rearm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // Count register is one bit wider than the address so that DEPTH itself fits.
  localparam int          CW      = ADDR_W + 1;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNT_LO = 3'd1;
  localparam logic [2:0] S_CNT_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        state_q,     state_d;
  logic [1:0]        byte_idx_q,  byte_idx_d;
  logic [ADDR_W-1:0] word_idx_q,  word_idx_d;
  logic [7:0]        cnt_lo_q,    cnt_lo_d;
  logic [CW-1:0]     cnt_q,       cnt_d;
  logic [7:0]        csum_q,      csum_d;
  logic [23:0]       asm_q,       asm_d;
  logic              rx_ready_q,  rx_ready_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q,  cpu_hold_d;
  logic              done_q,      done_d;
  logic              error_q,     error_d;

  logic        xfer;
  logic [15:0] count16;
  logic        last_word;

  assign xfer      = rx_valid && rx_ready_q;
  assign count16   = {rx_data, cnt_lo_q};
  assign last_word = (word_idx_q == ADDR_W'(cnt_q - CW'(1)));

  // Next-state, datapath and registered-output computation for the frame parser.
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    cnt_lo_d    = cnt_lo_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        csum_d = 8'h00;
        if (xfer && (rx_data == SYNC)) begin
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (xfer) begin
          cnt_lo_d = rx_data;
          csum_d   = csum_q ^ rx_data;
          state_d  = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (xfer) begin
          csum_d = csum_q ^ rx_data;
          if (count16 > DEPTH16) begin
            state_d = S_ERR;
          end else if (count16 == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            cnt_d      = count16[CW-1:0];
            byte_idx_d = 2'd0;
            word_idx_d = '0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ rx_data;
          if (byte_idx_q == 2'd3) begin
            // Fourth byte completes the word: write it on the next cycle.
            mem_we_d    = 1'b1;
            mem_addr_d  = word_idx_q;
            mem_wdata_d = {rx_data, asm_q};
            word_idx_d  = word_idx_q + ADDR_W'(1);
            byte_idx_d  = 2'd0;
            if (last_word) begin
              state_d = S_CSUM;
            end
          end else begin
            case (byte_idx_q)
              2'd0:    asm_d[7:0]   = rx_data;
              2'd1:    asm_d[15:8]  = rx_data;
              default: asm_d[23:16] = rx_data;
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (rearm) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs follow the state being entered; the write cycle stalls input.
    rx_ready_d = (state_d != S_DONE) && (state_d != S_ERR) && !mem_we_d;
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    cpu_hold_d = (state_d != S_DONE);
  end

  // State and output registers; reset returns everything to the idle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      byte_idx_q  <= 2'd0;
      word_idx_q  <= '0;
      cnt_lo_q    <= 8'h00;
      cnt_q       <= '0;
      csum_q      <= 8'h00;
      asm_q       <= 24'h0;
      rx_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      cnt_lo_q    <= cnt_lo_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      asm_q       <= asm_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: frames are built from a word list, expected memory
// writes are queued as the completing byte is sent and checked as they appear.
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              rearm = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int vectors = 0;
  int miscompares = 0;
  int last_stall = 0;

  logic [31:0]        wl [0:DEPTH-1];
  logic [ADDR_W+31:0] sb [$];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rearm(rearm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write", mem_addr, mem_wdata);
      end else begin
        logic [ADDR_W+31:0] exp;
        exp = sb.pop_front();
        if ({mem_addr, mem_wdata} !== exp) begin
          miscompares++;
          $display("FAIL mem_write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                   mem_addr, mem_wdata, exp[ADDR_W+31:32], exp[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    last_stall = n;
    if (n >= 16) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: byte %02h not accepted, rx_ready=%b required 1", b, rx_ready);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends a frame of nw words from wl; csum_xor corrupts the checksum when non-zero.
  task automatic send_frame(input int nw, input logic [7:0] csum_xor, input bit bp);
    logic [7:0] cs;
    logic [7:0] b;
    logic [31:0] w;
    bit prev_b3;
    cs = nw[7:0] ^ nw[15:8];
    send_byte(8'hA5);
    send_byte(nw[7:0]);
    send_byte(nw[15:8]);
    prev_b3 = 1'b0;
    for (int i = 0; i < nw; i++) begin
      w = wl[i];
      for (int k = 0; k < 4; k++) begin
        b  = w[8*k +: 8];
        cs = cs ^ b;
        if (k == 3) sb.push_back({ADDR_W'(i), w});
        send_byte(b);
        if (bp) begin
          vectors++;
          if (last_stall != (prev_b3 ? 1 : 0)) begin
            miscompares++;
            $display("FAIL bp_stall: word %0d byte %0d stalled %0d cycles, required %0d", i, k, last_stall, prev_b3 ? 1 : 0);
          end
          vectors++;
          if (rx_ready !== (k != 3) || (k == 3 && mem_we !== 1'b1)) begin
            miscompares++;
            $display("FAIL bp_ready: word %0d byte %0d rx_ready=%b mem_we=%b, required rx_ready=%b", i, k, rx_ready, mem_we, k != 3);
          end
        end
        prev_b3 = (k == 3);
      end
    end
    send_byte(cs ^ csum_xor);
    rx_valid = 1'b0;
  endtask

  task automatic check_status(input string name, input logic d, e, h, r);
    vectors++;
    if ({done, error, cpu_hold, rx_ready} !== {d, e, h, r}) begin
      miscompares++;
      $display("FAIL %s: done/error/cpu_hold/rx_ready = %b%b%b%b, required %b%b%b%b",
               name, done, error, cpu_hold, rx_ready, d, e, h, r);
    end
  endtask

  task automatic check_sb_empty(input string name);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected writes missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_rearm(input string name);
    @(negedge clk);
    rearm = 1'b1;
    @(posedge clk);
    #1;
    rearm = 1'b0;
    check_status(name, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_status("reset_status", 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if ({mem_we, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_mem: we=%b addr=%0d data=%08h, required all 0", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load;
    wl[0] = 32'h00100013;
    wl[1] = 32'h00200093;
    send_frame(2, 8'h00, 1'b0);
    check_status("load_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_sb_empty("load_writes");
    do_rearm("load_rearm");
  endtask

  task automatic test_back_to_back;
    send_frame(2, 8'h00, 1'b1);
    check_status("bp_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_sb_empty("bp_writes");
    do_rearm("bp_rearm");
  endtask

  task automatic test_garbage;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_frame(2, 8'h00, 1'b0);
    check_status("garbage_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_sb_empty("garbage_writes");
    do_rearm("garbage_rearm");
  endtask

  task automatic test_bad_csum;
    send_frame(2, 8'h01, 1'b0);
    check_status("badcsum_err", 1'b0, 1'b1, 1'b1, 1'b0);
    check_sb_empty("badcsum_writes");
    do_rearm("badcsum_rearm");
  endtask

  task automatic test_oversize_empty;
    send_byte(8'hA5);
    send_byte(8'h21);
    send_byte(8'h00);
    rx_valid = 1'b0;
    check_status("oversize_err", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    check_sb_empty("oversize_nowrite");
    do_rearm("oversize_rearm");
    send_frame(0, 8'h00, 1'b0);
    check_status("empty_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_sb_empty("empty_nowrite");
    do_rearm("empty_rearm");
  endtask

  task automatic test_full_depth;
    for (int i = 0; i < DEPTH; i++) wl[i] = $urandom;
    send_frame(DEPTH, 8'h00, 1'b0);
    check_status("full_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_sb_empty("full_writes");
    do_rearm("full_rearm");
  endtask

  task automatic test_reset_mid;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_status("midreset_status", 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if ({mem_we, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL midreset_mem: we=%b addr=%0d data=%08h, required all 0", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    check_sb_empty("midreset_nowrite");
    wl[0] = 32'h00100013;
    wl[1] = 32'h00200093;
    send_frame(2, 8'h00, 1'b0);
    check_status("midreset_reload", 1'b1, 1'b0, 1'b0, 1'b0);
    check_sb_empty("midreset_writes");
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_garbage();
    test_bad_csum();
    test_oversize_empty();
    test_full_depth();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
